// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush resolution for an in-order pipeline with NUM_REGS pipeline
// registers. Requests are resolved oldest stage first. A flush always wins
// over a stall on the same register or the PC. Flush pulses that arrive
// while their stage is frozen behind an older stall are kept in `pending`.
// They are applied once the stage becomes eligible. The block also keeps
// saturating stall/flush counters and a sticky stall watchdog.
module pipe_hazard_ctrl #(
    parameter int NUM_REGS  = 4,
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REGS:0]    stall_req,
    input  logic [NUM_REGS:0]    flush_req,
    input  logic                 perf_clr,
    output logic                 pc_stall,
    output logic                 pc_flush,
    output logic [NUM_REGS-1:0]  reg_stall,
    output logic [NUM_REGS-1:0]  reg_flush,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events,
    output logic                 stall_timeout
);

    localparam int RUN_W = (TIMEOUT > 0 && $clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RUN_W-1:0]     RUN_MAX  = RUN_W'(TIMEOUT);
    localparam logic [RUN_W-1:0]     RUN_ONE  = RUN_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    logic [NUM_REGS:0]   pending_r;
    logic [NUM_REGS:0]   pending_vis_s;
    logic [NUM_REGS:0]   flush_eff_s;
    logic [NUM_REGS:0]   pending_nxt_s;
    logic                s_valid_s;
    logic                f_valid_s;
    int                  s_idx_s;
    int                  f_idx_s;
    logic [RUN_W-1:0]    run_r;
    logic [RUN_W-1:0]    run_nxt_s;
    logic [NUM_REGS-1:0] hold_s;
    logic [NUM_REGS-1:0] kill_s;

    // Resolve the oldest stall and the oldest eligible flush into controls.
    always_comb begin
        if (reset) begin
            pending_vis_s = {(NUM_REGS+1){1'b0}};
        end else begin
            pending_vis_s = pending_r;
        end
        flush_eff_s   = flush_req | pending_vis_s;
        s_valid_s     = 1'b0;
        s_idx_s       = 0;
        f_valid_s     = 1'b0;
        f_idx_s       = 0;
        pending_nxt_s = {(NUM_REGS+1){1'b0}};
        hold_s        = {NUM_REGS{1'b0}};
        kill_s        = {NUM_REGS{1'b0}};

        for (int s = 0; s <= NUM_REGS; s++) begin
            if (stall_req[s]) begin
                s_valid_s = 1'b1;
                s_idx_s   = s;
            end else begin
                s_valid_s = s_valid_s;
            end
        end

        // A flush is only eligible when it is older than the stalling stage.
        for (int f = 0; f <= NUM_REGS; f++) begin
            if (flush_eff_s[f] && (!s_valid_s || f > s_idx_s)) begin
                f_valid_s = 1'b1;
                f_idx_s   = f;
            end else begin
                f_valid_s = f_valid_s;
            end
        end

        // Flushes that are blocked by the stall are retained for later.
        for (int f = 0; f <= NUM_REGS; f++) begin
            pending_nxt_s[f] = flush_eff_s[f] & s_valid_s & (f <= s_idx_s) & ~f_valid_s;
        end

        for (int j = 0; j < NUM_REGS; j++) begin
            hold_s[j] = s_valid_s & (j < s_idx_s);
            kill_s[j] = (s_valid_s & (j == s_idx_s)) | (f_valid_s & (j < f_idx_s));
        end

        pc_flush  = f_valid_s;
        pc_stall  = s_valid_s & ~f_valid_s;
        reg_flush = kill_s;
        reg_stall = hold_s & ~kill_s;

        if (s_valid_s && !f_valid_s) begin
            if (run_r != RUN_MAX) begin
                run_nxt_s = run_r + RUN_ONE;
            end else begin
                run_nxt_s = run_r;
            end
        end else begin
            run_nxt_s = {RUN_W{1'b0}};
        end
    end

    // Pending flushes, watchdog run length and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r     <= {(NUM_REGS+1){1'b0}};
            run_r         <= {RUN_W{1'b0}};
            stall_timeout <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            if (perf_clr) begin
                run_r         <= {RUN_W{1'b0}};
                stall_timeout <= 1'b0;
            end else begin
                run_r <= run_nxt_s;
                if (TIMEOUT > 0 && run_nxt_s == RUN_MAX) begin
                    stall_timeout <= 1'b1;
                end else begin
                    stall_timeout <= stall_timeout;
                end
            end
        end
    end

    // Saturating performance counters. A clear beats a same-cycle event.
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            stall_cycles <= CNT_ZERO;
            flush_events <= CNT_ZERO;
        end else begin
            if (pc_stall && stall_cycles != CNT_MAX) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (pc_flush && flush_events != CNT_MAX) begin
                flush_events <= flush_events + CNT_ONE;
            end else begin
                flush_events <= flush_events;
            end
        end
    end

endmodule
